// File: rtl/imem_loader.sv
// imem_loader: takes a byte stream over valid/ready, packs four bytes
// little-endian into a 32-bit word and issues one-cycle word writes
// (word-indexed address) to the instruction memory write port.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, one
// trailing checksum byte is accepted and verified after the last word.
//
// Handshake: a byte is consumed on a rising clk edge where in_valid_i and
// in_ready_o are both high. in_ready_o is a registered output, so the source
// may look at it any time during the cycle. Bytes offered while in_ready_o is
// low stay with the source.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [1:0]       bcnt_q;
    logic [23:0]      word_q;
    logic             in_ready_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             take_d;
    logic             last_word_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       chk_q;
    logic [7:0] sum_d;
`endif

    // Handshake and end-of-load decode shared by several states.
    always_comb begin
        take_d      = in_valid_i && in_ready_q;
        last_word_d = (idx_q == (cnt_q - CNT_W'(1)));
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q + in_data_i;
`endif
    end

    // Load sequencer: all state and outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            chk_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (start_i) begin
                        cnt_q <= word_count_i;
                        if (word_count_i == '0) begin
                            done_q <= 1'b1;
                        end else if (word_count_i > CNT_W'(DEPTH)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= S_LOAD;
                            idx_q      <= '0;
                            bcnt_q     <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum_q      <= '0;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    if (take_d) begin
                        bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q  <= sum_d;
`endif
                        case (bcnt_q)
                            2'd0: word_q[7:0]   <= in_data_i;
                            2'd1: word_q[15:8]  <= in_data_i;
                            2'd2: word_q[23:16] <= in_data_i;
                            default: begin
                                // Fourth byte completes the word: write it next cycle.
                                state_q     <= S_WRITE;
                                in_ready_q  <= 1'b0;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= {{(32-CNT_W){1'b0}}, idx_q};
                                mem_wdata_q <= {in_data_i, word_q};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    if (last_word_d) begin
                        state_q <= S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_q      <= 1'b1;
                        in_ready_q <= 1'b1;
`else
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q    <= S_LOAD;
                        idx_q      <= idx_q + CNT_W'(1);
                        bcnt_q     <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (chk_q) begin
                        // Wait for the checksum byte; result pulses while still in FIN.
                        if (take_d) begin
                            chk_q      <= 1'b0;
                            in_ready_q <= 1'b0;
                            if (sum_d == 8'h00) done_q <= 1'b1;
                            else                err_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
`else
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads, a queue-based model of the expected
// memory writes and completion events, and a per-cycle compare process.
module tb_imem_loader;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       dbg_state;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .word_count_i (word_count),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // scoreboard: {addr, data} of expected writes, and expected events (01 done, 10 err)
    logic [63:0] exp_q[$];
    logic [1:0]  exp_evt_q[$];
    logic [7:0]  model_bytes[$];
    int          n_writes = 0;
    logic [31:0] last_data = '0;
    int          wr_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: each word is four consecutive bytes, first byte least significant.
    task automatic push_words(input int nwords);
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] d;
            d = 32'(model_bytes[4*w]) + (32'(model_bytes[4*w+1]) * 256)
              + (32'(model_bytes[4*w+2]) * 65536) + (32'(model_bytes[4*w+3]) * 16777216);
            exp_q.push_back({32'(w), d});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // compare process: every write and every completion pulse is checked
    initial begin
        logic [63:0] e;
        logic [1:0]  ev;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (mem_we) begin
                    n_writes++;
                    wr_cyc.push_back(cyc);
                    last_data = mem_wdata;
                    check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("mem_addr", mem_addr, e[63:32]);
                        check("mem_wdata", mem_wdata, e[31:0]);
                    end
                    check("ready_low_in_write", 32'(in_ready), 32'd0);
                end
                if (done || err) begin
                    check("event_expected", 32'(exp_evt_q.size() > 0), 32'd1);
                    if (exp_evt_q.size() > 0) begin
                        ev = exp_evt_q.pop_front();
                        check("event_kind", 32'({err, done}), 32'(ev));
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic start_load(input int cnt);
        start      = 1'b1;
        word_count = CNT_W'(cnt);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check("byte_accept_timeout", 32'(ok), 32'd1);
    endtask

    // After the last payload byte: leaves the bench at the negedge where the
    // completion pulse is visible.
    task automatic end_load();
        in_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (model_bytes[i]) s = s + model_bytes[i];
            send_byte(8'h00 - s);
            in_valid = 1'b0;
        end
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        int base;
        reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: two words, valid held high
        model_bytes = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        push_words(2);
        check("t1_model_word0", exp_q[0][31:0], 32'h00500013);
        exp_evt_q.push_back(2'b01);
        wr_cyc.delete();
        base = n_writes;
        start_load(2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        foreach (model_bytes[i]) send_byte(model_bytes[i]);
        end_load();
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_in_fin", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_writes", 32'(n_writes - base), 32'd2);
        check("t1_word1", last_data, 32'h00100093);
        if (wr_cyc.size() == 2) check("t1_five_cycles", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
        else check("t1_write_count", 32'(wr_cyc.size()), 32'd2);

        // 2: one word, valid toggling, junk on the data bus when not valid
        model_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_words(1);
        exp_evt_q.push_back(2'b01);
        base = n_writes;
        start_load(1);
        for (int i = 0; i < 4; i++) begin
            send_byte(model_bytes[i]);
            if (i < 3) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                @(negedge clk);
            end
        end
        end_load();
        check("t2_done", 32'(done), 32'd1);
        check("t2_word", last_data, 32'hDEADBEEF);
        check("t2_writes", 32'(n_writes - base), 32'd1);
        @(negedge clk);

        // 3: count above DEPTH is rejected
        exp_evt_q.push_back(2'b10);
        base = n_writes;
        start_load(DEPTH + 1);
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t3_err_pulse", 32'(err), 32'd0);
        check("t3_no_writes", 32'(n_writes - base), 32'd0);

        // 4: reset after six bytes of a three-word load
        model_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        push_words(1);
        base = n_writes;
        start_load(3);
        foreach (model_bytes[i]) send_byte(model_bytes[i]);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("t4_rst_outputs", 32'({in_ready, mem_we, busy, done, err}), 32'd0);
        check("t4_rst_addr", mem_addr, 32'd0);
        check("t4_rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t4_only_idx0", 32'(n_writes - base), 32'd1);
        check("t4_model_drained", 32'(exp_q.size()), 32'd0);
        model_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        push_words(1);
        exp_evt_q.push_back(2'b01);
        start_load(1);
        foreach (model_bytes[i]) send_byte(model_bytes[i]);
        end_load();
        check("t4_done", 32'(done), 32'd1);
        check("t4_word", last_data, 32'hD4C3B2A1);
        @(negedge clk);

        // 5: zero-length load, then start ignored during a load
        exp_evt_q.push_back(2'b01);
        start_load(0);
        check("t5_zero_done", 32'(done), 32'd1);
        check("t5_zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_zero_pulse", 32'(done), 32'd0);
        model_bytes = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40};
        push_words(2);
        exp_evt_q.push_back(2'b01);
        base = n_writes;
        start_load(2);
        for (int i = 0; i < 8; i++) begin
            start      = (i == 2 || i == 5);
            word_count = CNT_W'(1);
            send_byte(model_bytes[i]);
        end
        start = 1'b0;
        end_load();
        check("t5_done", 32'(done), 32'd1);
        check("t5_writes", 32'(n_writes - base), 32'd2);
        check("t5_word1", last_data, 32'h40043003);
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum pass then fail; word is written either way
        model_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int pass = 0; pass < 2; pass++) begin
            push_words(1);
            exp_evt_q.push_back(pass == 0 ? 2'b01 : 2'b10);
            base = n_writes;
            start_load(1);
            foreach (model_bytes[i]) send_byte(model_bytes[i]);
            in_valid = 1'b0;
            send_byte(pass == 0 ? 8'hF6 : 8'hF7);
            in_valid = 1'b0;
            check("t6_result", 32'({err, done}), (pass == 0) ? 32'd1 : 32'd2);
            check("t6_word", last_data, 32'h04030201);
            check("t6_writes", 32'(n_writes - base), 32'd1);
            @(negedge clk);
            check("t6_idle", 32'(busy), 32'd0);
        end
`endif

        repeat (2) @(negedge clk);
        check("final_writes_drained", 32'(exp_q.size()), 32'd0);
        check("final_events_drained", 32'(exp_evt_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
